program_counter: RTL and testbench
==================================

# program_counter

Program counter for the Hack-style CPU datapath. It consumes the 16-bit value held in the A register as a jump target and the ALU status flags (zr, ng). Each cycle it decides whether to jump, increment, or hold, and drives the instruction address to ROM. It is the stage directly downstream of the A/D registers: the register output feeds `in`, and the register's load/in timing conventions apply unchanged.

## Interface
Parameters:
- `WIDTH`, default 16: address/data width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high; sampled on the rising edge of `clk`.
- `in`  in  WIDTH  — jump target (A register output), signed two's complement.
- `jmp`  in  3  — jump bits {j1,j2,j3}: j1 = jump if ALU out < 0, j2 = jump if == 0, j3 = jump if > 0.
- `zr`  in  1  — ALU result is zero.
- `ng`  in  1  — ALU result is negative.
- `inc`  in  1  — advance to the next address.
- `stall`  in  1  — freeze all state this cycle.
- `out`  out  WIDTH  — current instruction address (registered).
- `jumped`  out  1  — registered; high for exactly the cycle after a taken jump.
- `jump_count`  out  WIDTH  — taken-jump counter; present only with `PC_JUMP_COUNT_EN`.

## Operation
- Taken jump: `taken = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr)`.
  - `jmp = 3'b000`: never taken.
  - `jmp = 3'b111`: always taken.
- Flags are evaluated literally, with no sanity check. `zr=1, ng=1` with `jmp=3'b010` is a taken jump.
- Priority per edge, highest first:
  1. reset
  2. stall
  3. taken jump
  4. inc
  5. hold
- reset: `out<=0`, `jumped<=0`, `jump_count<=0`.
- stall (not reset): `out`, `jumped` and `jump_count` all hold. A taken jump that coincides with stall is dropped, not deferred.
- taken jump: `out<=in` (the raw bit pattern; negative targets are legal addresses), `jumped<=1`.
- inc (no jump): `out<=out+1`, modulo 2^WIDTH. 16'hFFFF wraps to 16'h0000 with no flag. `jumped<=0`.
- hold (none of the above): `out` unchanged, `jumped<=0`.
- The jump overrides inc when both apply; the increment is discarded.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `out` after edge N.
- No combinational path from any input to any output.
- Reset takes effect on the first edge where it is high, including mid-stall and mid-increment sequences. Outputs are zero from the next cycle onward while reset remains high.
- Reset values: `out=0`, `jumped=0`, `jump_count=0`.

## Configuration
- Macro: `PC_JUMP_COUNT_EN`.
- Defined:
  - `jump_count` port exists.
  - It increments by 1 on every edge where a jump is taken (not reset, not stall).
  - It saturates at 2^WIDTH-1 and does not wrap.
  - It is cleared by reset.
- Undefined: the port, its register and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - `WIDTH` default (16);
  - jump-field encodings `JMP_NULL=3'b000`, `JMP_JGT=3'b001`, `JMP_JEQ=3'b010`, `JMP_JGE=3'b011`, `JMP_JLT=3'b100`, `JMP_JNE=3'b101`, `JMP_JLE=3'b110`, `JMP_JMP=3'b111`.
- Sub-module `jump_cond`: purely combinational, taking (`jmp`, `zr`, `ng`) and producing `taken`. It is reused by the CPU decode checker.
- The top level holds the `out`, `jumped` and `jump_count` registers and the priority mux.

## Test plan
- Reset with `inc=1` for 3 cycles, then release with `inc=1` → `out` stays 0 during reset, then reads 1, 2, 3 on successive cycles; `jumped=0` throughout.
- `out=5`, `in=-32123`, `jmp=3'b111`, `inc=1` → next `out=16'h8285` (-32123), `jumped=1` for one cycle, then `out=16'h8286` with `inc=1`.
- Every `jmp` value 0–7 against the flag pairs (zr,ng) = (0,0), (1,0), (0,1), with `in=11111` and `out=100` → `out=11111` exactly when the formula is true, else 101.
- `out=16'hFFFF`, `inc=1` → `out=0`, `jumped=0`.
- `stall=1` with `jmp=3'b111`, `in=42`, `out=7` → `out` stays 7 and the jump is lost once stall drops (`jmp=0`, `inc=1` gives 8); reset asserted together with stall → `out=0`.
- With `PC_JUMP_COUNT_EN`: 3 taken jumps plus 1 stalled jump → `jump_count=3`; preset the counter to 16'hFFFF, take a jump → it stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Hack-style CPU datapath: default width,
// jump-field encodings and the program-counter update selector.
package cpu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        JMP_NULL = 3'b000,
        JMP_JGT  = 3'b001,
        JMP_JEQ  = 3'b010,
        JMP_JGE  = 3'b011,
        JMP_JLT  = 3'b100,
        JMP_JNE  = 3'b101,
        JMP_JLE  = 3'b110,
        JMP_JMP  = 3'b111
    } jmp_e;

    // Resolved action for one edge, already in priority order.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_STALL
    } pc_op_e;

endpackage

// File: rtl/jump_cond.sv
// Jump condition evaluator: decides from the jump field and ALU flags whether
// a jump is taken. Purely combinational; flags are used exactly as given.
module jump_cond
    import cpu_pkg::*;
(
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    logic is_lt;
    logic is_eq;
    logic is_gt;

    assign is_lt = ng;
    assign is_eq = zr;
    assign is_gt = ~ng & ~zr;

    assign taken = (jmp[2] & is_lt) | (jmp[1] & is_eq) | (jmp[0] & is_gt);

endmodule

// File: rtl/program_counter.sv
// Program counter: jump / increment / hold with stall and synchronous reset.
// Optional taken-jump counter is enabled with the PC_JUMP_COUNT_EN macro.
module program_counter #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic             inc,
    input  logic             stall,
    output logic [WIDTH-1:0] out,
`ifdef PC_JUMP_COUNT_EN
    output logic [WIDTH-1:0] jump_count,
`endif
    output logic             jumped
);

    import cpu_pkg::*;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             taken;
    pc_op_e           op;
    logic [WIDTH-1:0] out_q, out_d;
    logic             jumped_q, jumped_d;

    jump_cond u_jump_cond (
        .jmp   (jmp),
        .zr    (zr),
        .ng    (ng),
        .taken (taken)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op = PC_HOLD;
        if (stall)      op = PC_STALL;
        else if (taken) op = PC_JUMP;
        else if (inc)   op = PC_INC;
    end

    always_comb begin
        out_d    = out_q;
        jumped_d = 1'b0;
        case (op)
            PC_STALL: jumped_d = jumped_q;
            PC_JUMP: begin
                out_d    = in;
                jumped_d = 1'b1;
            end
            PC_INC:  out_d = out_q + ONE;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            jumped_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            jumped_q <= jumped_d;
        end
    end

    assign out    = out_q;
    assign jumped = jumped_q;

`ifdef PC_JUMP_COUNT_EN
    logic [WIDTH-1:0] jump_count_q, jump_count_d;

    // Saturating: once all ones, further taken jumps leave the count unchanged.
    always_comb begin
        jump_count_d = jump_count_q;
        if (op == PC_JUMP && jump_count_q != '1) jump_count_d = jump_count_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) jump_count_q <= '0;
        else       jump_count_q <= jump_count_d;
    end

    assign jump_count = jump_count_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed sequences, a jump-condition
// vector table and randomized traffic against a behavioural model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset, stall, inc, zr, ng;
    logic [2:0]  jmp;
    logic [15:0] pc_in;
    logic [15:0] out;
    logic        jumped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef PC_JUMP_COUNT_EN
    logic [15:0] jump_count;
    logic        s_reset;
    logic [3:0]  s_out, s_count;
    logic        s_jumped;

    program_counter dut (
        .clk(clk), .reset(reset), .in(pc_in), .jmp(jmp), .zr(zr), .ng(ng),
        .inc(inc), .stall(stall), .out(out), .jump_count(jump_count), .jumped(jumped)
    );

    // Narrow instance so counter saturation is reachable in a few cycles.
    program_counter #(.WIDTH(4)) dut_sat (
        .clk(clk), .reset(s_reset), .in(4'd3), .jmp(3'b111), .zr(1'b0), .ng(1'b0),
        .inc(1'b0), .stall(1'b0), .out(s_out), .jump_count(s_count), .jumped(s_jumped)
    );
`else
    program_counter dut (
        .clk(clk), .reset(reset), .in(pc_in), .jmp(jmp), .zr(zr), .ng(ng),
        .inc(inc), .stall(stall), .out(out), .jumped(jumped)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and return 1 time unit later, away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic i,
                         input logic [2:0] j, input logic z, input logic n,
                         input logic [15:0] d);
        reset = r; stall = s; inc = i; jmp = j; zr = z; ng = n; pc_in = d;
    endtask

    task automatic load_pc(input logic [15:0] v);
        drive(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, v);
        cycle();
    endtask

    typedef struct {
        logic [2:0]  jmp;
        logic        zr;
        logic        ng;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[25];

    // Reference: a jump fires when the ALU result's sign class is selected by the jump field.
    function automatic logic model_taken(input logic [2:0] j, input logic z, input logic n);
        bit lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
    endfunction

    initial begin
        int          m_pc;
        bit          m_jumped;
        int          m_count;
        logic [2:0]  jv;
        logic        tk;

        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 16'd0);
`ifdef PC_JUMP_COUNT_EN
        s_reset = 1'b1;
`endif

        // Reset with inc held high, then count up.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_out", 32'(out), 32'd0);
            check("reset_jumped", 32'(jumped), 32'd0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("inc_after_reset", 32'(out), 32'(i));
            check("inc_jumped", 32'(jumped), 32'd0);
        end

        // Negative jump target from out=5, then increment past it.
        load_pc(16'd5);
        drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h8285);
        cycle();
        check("neg_jump_out", 32'(out), 32'h8285);
        check("neg_jump_jumped", 32'(jumped), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0);
        cycle();
        check("neg_jump_inc", 32'(out), 32'h8286);
        check("neg_jump_jumped_clr", 32'(jumped), 32'd0);

        // Wrap at all ones.
        load_pc(16'hFFFF);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0);
        cycle();
        check("wrap_out", 32'(out), 32'd0);
        check("wrap_jumped", 32'(jumped), 32'd0);

        // Stalled jump is dropped; reset beats stall.
        load_pc(16'd7);
        drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'd42);
        cycle();
        check("stall_out", 32'(out), 32'd7);
        check("stall_jumped_hold", 32'(jumped), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 16'd42);
        cycle();
        check("stall_dropped", 32'(out), 32'd8);
        drive(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'd42);
        cycle();
        check("reset_over_stall", 32'(out), 32'd0);
        check("reset_over_stall_j", 32'(jumped), 32'd0);

        // Jump-condition table: flag class (0,0)->gt bit0, (1,0)->eq bit1, (0,1)->lt bit2.
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 8; j++) begin
                jv = 3'(j);
                vecs[f*8+j].jmp = jv;
                vecs[f*8+j].zr  = (f == 1);
                vecs[f*8+j].ng  = (f == 2);
                vecs[f*8+j].exp_out = jv[f] ? 16'd11111 : 16'd101;
            end
        end
        vecs[24] = '{jmp: 3'b010, zr: 1'b1, ng: 1'b1, exp_out: 16'd11111};

        for (int v = 0; v < 25; v++) begin
            load_pc(16'd100);
            drive(1'b0, 1'b0, 1'b1, vecs[v].jmp, vecs[v].zr, vecs[v].ng, 16'd11111);
            cycle();
            check($sformatf("cond_j%0d_z%0d_n%0d", vecs[v].jmp, vecs[v].zr, vecs[v].ng),
                  32'(out), 32'(vecs[v].exp_out));
        end

`ifdef PC_JUMP_COUNT_EN
        // Three taken jumps plus one stalled jump.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'd0);
        cycle();
        check("count_reset", 32'(jump_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 16'(i * 10));
            cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'd99);
        cycle();
        check("count_three", 32'(jump_count), 32'd3);

        s_reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("count_saturate", 32'(s_count), 32'hF);
        s_reset = 1'b1;
        cycle();
        check("count_sat_reset", 32'(s_count), 32'd0);
`endif

        // Randomized traffic against the behavioural model.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'd0);
        cycle();
        m_pc = 0;
        m_jumped = 0;
        m_count = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            tk = model_taken(jmp, zr, ng);
            if (reset) begin
                m_pc = 0; m_jumped = 0; m_count = 0;
            end else if (stall) begin
                // everything holds
            end else if (tk) begin
                m_pc = int'(pc_in); m_jumped = 1;
                if (m_count < 65535) m_count++;
            end else begin
                if (inc) m_pc = (m_pc + 1) % 65536;
                m_jumped = 0;
            end
            cycle();
            check("rand_out", 32'(out), 32'(m_pc));
            check("rand_jumped", 32'(jumped), 32'(m_jumped));
`ifdef PC_JUMP_COUNT_EN
            check("rand_count", 32'(jump_count), 32'(m_count));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
